// File: rtl/numpad_emulator.sv
// 4x4 keypad model: presses a latched key for HOLD_CYCLES, then forces a GAP_CYCLES release.
// Row responds to Col with one cycle of latency; requests are taken only in IDLE and never queued.
module numpad_emulator #(
    parameter int HOLD_CYCLES = 500000,
    parameter int GAP_CYCLES  = 200000,
    parameter int CNT_W       = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    input  logic [3:0] Col,
    output logic [3:0] Row,
    output logic       busy,
    output logic       press_done,
    output logic [7:0] hit_count
);

    typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [3:0]       key_q;
    logic [1:0]       col_idx;
    logic [1:0]       row_idx;
    logic             col_hit;

    // Bit indices into Col/Row: C1/R1 are bit 3, C4/R4 are bit 0.
    always_comb begin
        col_idx = 2'd3;
        row_idx = 2'd0;
        case (key_q)
            4'h1: begin col_idx = 2'd3; row_idx = 2'd3; end
            4'h4: begin col_idx = 2'd3; row_idx = 2'd2; end
            4'h7: begin col_idx = 2'd3; row_idx = 2'd1; end
            4'h0: begin col_idx = 2'd3; row_idx = 2'd0; end
            4'h2: begin col_idx = 2'd2; row_idx = 2'd3; end
            4'h5: begin col_idx = 2'd2; row_idx = 2'd2; end
            4'h8: begin col_idx = 2'd2; row_idx = 2'd1; end
            4'hF: begin col_idx = 2'd2; row_idx = 2'd0; end
            4'h3: begin col_idx = 2'd1; row_idx = 2'd3; end
            4'h6: begin col_idx = 2'd1; row_idx = 2'd2; end
            4'h9: begin col_idx = 2'd1; row_idx = 2'd1; end
            4'hE: begin col_idx = 2'd1; row_idx = 2'd0; end
            4'hA: begin col_idx = 2'd0; row_idx = 2'd3; end
            4'hB: begin col_idx = 2'd0; row_idx = 2'd2; end
            4'hC: begin col_idx = 2'd0; row_idx = 2'd1; end
            4'hD: begin col_idx = 2'd0; row_idx = 2'd0; end
            default: begin col_idx = 2'd3; row_idx = 2'd0; end
        endcase
    end

    assign col_hit   = (state == PRESS) && !Col[col_idx];
    assign key_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            counter    <= '0;
            key_q      <= 4'h0;
            Row        <= 4'b1111;
            press_done <= 1'b0;
            hit_count  <= 8'd0;
        end else begin
            press_done <= 1'b0;
            Row        <= col_hit ? ~(4'b0001 << row_idx) : 4'b1111;
            if (col_hit && hit_count != 8'hFF)
                hit_count <= hit_count + 8'd1;
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        key_q     <= key_code;
                        counter   <= '0;
                        hit_count <= 8'd0;
                        state     <= PRESS;
                    end
                end
                PRESS: begin
                    if (counter == HOLD_LAST) begin
                        counter    <= '0;
                        press_done <= 1'b1;
                        state      <= RELEASE;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                RELEASE: begin
                    if (counter == GAP_LAST) begin
                        counter <= '0;
                        state   <= IDLE;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_numpad_emulator.sv
// Directed bench for numpad_emulator with HOLD=40, GAP=10.
module tb_numpad_emulator;

    localparam int HOLD = 40;
    localparam int GAP  = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic [3:0] Col;
    logic [3:0] Row;
    logic       busy;
    logic       press_done;
    logic [7:0] hit_count;

    int errors = 0;
    int checks = 0;

    // Keypad layout as printed: kp[c][r], c=0 is C1 (Col[3]), r=0 is R1 (Row[3]).
    logic [3:0] kp[4][4] = '{'{4'h1, 4'h4, 4'h7, 4'h0},
                             '{4'h2, 4'h5, 4'h8, 4'hF},
                             '{4'h3, 4'h6, 4'h9, 4'hE},
                             '{4'hA, 4'hB, 4'hC, 4'hD}};
    logic [3:0] scan[4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    numpad_emulator #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .Col(Col), .Row(Row), .busy(busy),
        .press_done(press_done), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_row(input logic [3:0] code, input logic [3:0] col);
        logic [3:0] r;
        r = 4'b1111;
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++)
                if (kp[c][k] == code && !col[3-c]) r[3-k] = 1'b0;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && !key_ready; i++) step();
        if (!key_ready) begin
            checks++; errors++;
            $display("FAIL wait_idle: key_ready=%0b required 1 within 200 cycles", key_ready);
        end
    endtask

    task automatic press_key(input logic [3:0] code);
        if (!key_ready) wait_idle();
        key_valid = 1'b1;
        key_code  = code;
        step();
        key_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0; Col = 4'b0000;
        step(); step();
        checks++; if (Row !== 4'b1111) begin errors++; $display("FAIL reset_row: got %b want 1111", Row); end
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", key_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (hit_count !== 8'd0) begin errors++; $display("FAIL reset_hits: got %0d want 0", hit_count); end
        checks++; if (press_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", press_done); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_key5_hold();
        Col = 4'b1011;
        press_key(4'h5);
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL k5_ready_drop: got %b want 0", key_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL k5_busy: got %b want 1", busy); end
        checks++; if (Row !== 4'b1111) begin errors++; $display("FAIL k5_row_first: got %b want 1111", Row); end
        for (int k = 1; k <= HOLD + GAP; k++) begin
            step();
            checks++;
            if (Row !== ((k <= HOLD) ? 4'b1011 : 4'b1111)) begin
                errors++; $display("FAIL k5_row cycle %0d: got %b want %b", k, Row, (k <= HOLD) ? 4'b1011 : 4'b1111);
            end
            checks++;
            if (press_done !== (k == HOLD)) begin
                errors++; $display("FAIL k5_done cycle %0d: got %b want %b", k, press_done, k == HOLD);
            end
            checks++;
            if (key_ready !== (k == HOLD + GAP)) begin
                errors++; $display("FAIL k5_ready cycle %0d: got %b want %b", k, key_ready, k == HOLD + GAP);
            end
        end
        checks++; if (hit_count !== 8'd40) begin errors++; $display("FAIL k5_hits: got %0d want 40", hit_count); end
    endtask

    task automatic test_keyD_cycling();
        logic [3:0] want;
        press_key(4'hD);
        for (int k = 1; k <= HOLD + GAP; k++) begin
            Col = scan[((k - 1) / 4) % 4];
            step();
            want = (k <= HOLD && Col == 4'b1110) ? 4'b1110 : 4'b1111;
            checks++;
            if (Row !== want) begin
                errors++; $display("FAIL kD_row cycle %0d: got %b want %b", k, Row, want);
            end
        end
        checks++; if (hit_count !== 8'd8) begin errors++; $display("FAIL kD_hits: got %0d want 8", hit_count); end
    endtask

    task automatic test_map_sweep();
        logic [3:0] want;
        for (int code = 0; code < 16; code++) begin
            press_key(4'(code));
            for (int k = 1; k <= HOLD + GAP; k++) begin
                Col = scan[(k - 1) % 4];
                step();
                want = (k <= HOLD) ? exp_row(4'(code), Col) : 4'b1111;
                checks++;
                if (Row !== want) begin
                    errors++; $display("FAIL map key %h cycle %0d col %b: got %b want %b", code, k, Col, Row, want);
                end
            end
        end
    endtask

    task automatic test_key1_all_cols();
        Col = 4'b0000;
        press_key(4'h1);
        step();
        checks++; if (Row !== 4'b0111) begin errors++; $display("FAIL k1_all_low: got %b want 0111", Row); end
        Col = 4'b1111;
        step();
        checks++; if (Row !== 4'b1111) begin errors++; $display("FAIL k1_all_high: got %b want 1111", Row); end
        Col = 4'b0000;
        step();
        checks++; if (Row !== 4'b0111) begin errors++; $display("FAIL k1_relow: got %b want 0111", Row); end
        wait_idle();
        checks++; if (hit_count !== 8'd39) begin errors++; $display("FAIL k1_hits: got %0d want 39", hit_count); end
    endtask

    task automatic test_mid_press_reset();
        Col = 4'b1101;
        press_key(4'h9);
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (Row !== 4'b1101) begin errors++; $display("FAIL k9_row cycle %0d: got %b want 1101", k, Row); end
        end
        rst_n = 1'b0;
        step();
        checks++; if (Row !== 4'b1111) begin errors++; $display("FAIL rst_mid_row: got %b want 1111", Row); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", key_ready); end
        checks++; if (hit_count !== 8'd0) begin errors++; $display("FAIL rst_mid_hits: got %0d want 0", hit_count); end
        rst_n = 1'b1;
        step();
        checks++; if (Row !== 4'b1111) begin errors++; $display("FAIL rst_mid_idle_row: got %b want 1111", Row); end
    endtask

    task automatic test_release_ignore();
        Col = 4'b1111;
        press_key(4'h2);
        for (int k = 1; k <= HOLD; k++) step();
        key_valid = 1'b1;
        key_code  = 4'h7;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (key_ready !== 1'b0) begin errors++; $display("FAIL rel_ready cycle %0d: got %b want 0", k, key_ready); end
        end
        key_valid = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL rel_back_idle: got %b want 1", key_ready); end
        Col = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (busy !== 1'b0 || Row !== 4'b1111) begin
                errors++; $display("FAIL rel_not_queued cycle %0d: busy=%b row=%b want busy=0 row=1111", k, busy, Row);
            end
        end
    endtask

    task automatic test_back_to_back();
        Col = 4'b1101;
        if (!key_ready) wait_idle();
        key_valid = 1'b1;
        key_code  = 4'h3;
        step();
        key_code  = 4'h6;
        for (int k = 1; k <= HOLD + GAP; k++) begin
            step();
            checks++;
            if (key_ready !== (k == HOLD + GAP)) begin
                errors++; $display("FAIL b2b_ready cycle %0d: got %b want %b", k, key_ready, k == HOLD + GAP);
            end
            if (k == 1) begin
                checks++;
                if (Row !== 4'b0111) begin errors++; $display("FAIL b2b_first_row: got %b want 0111", Row); end
            end
        end
        step();
        checks++; if (busy !== 1'b1 || key_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: busy=%b ready=%b want busy=1 ready=0", busy, key_ready);
        end
        key_valid = 1'b0;
        step();
        checks++; if (Row !== 4'b1011) begin errors++; $display("FAIL b2b_second_row: got %b want 1011", Row); end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_key5_hold();
        test_keyD_cycling();
        test_map_sweep();
        test_key1_all_cols();
        test_mid_press_reset();
        test_release_ignore();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
